// File: rtl/fft_out_serializer.sv
// Double-buffered serializer: streams one 8-point complex FFT/IFFT frame per element with valid/ready.
// Define IFFT_SCALE_EN to apply 1/8 round-half-up scaling to elements of IFFT (mode=1) frames.
module fft_out_serializer #(
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             load,
    input  logic [16*DW-1:0] y_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [DW-1:0]    out_re,
    output logic [DW-1:0]    out_im,
    output logic [2:0]       out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             load_drop
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state;
    logic [16*DW-1:0] act_frame, pend_frame;
    logic             act_mode, pend_mode, pend_full;
    logic [2:0]       idx;
    logic             xfer, last_xfer;
    logic [DW-1:0]    raw_re, raw_im;

    assign xfer      = (state == STREAM) && out_ready;
    assign last_xfer = xfer && (idx == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pend_full <= 1'b0;
            idx       <= 3'd0;
            load_drop <= 1'b0;
        end else begin
            load_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        act_frame <= y_in;
                        act_mode  <= mode;
                        idx       <= 3'd0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (last_xfer) begin
                        idx <= 3'd0;
                        // Pending frame (if any) always goes first; a coincident load queues behind it.
                        if (pend_full) begin
                            act_frame <= pend_frame;
                            act_mode  <= pend_mode;
                            if (load) begin
                                pend_frame <= y_in;
                                pend_mode  <= mode;
                            end else begin
                                pend_full <= 1'b0;
                            end
                        end else if (load) begin
                            act_frame <= y_in;
                            act_mode  <= mode;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (xfer)
                            idx <= idx + 3'd1;
                        if (load) begin
                            if (!pend_full) begin
                                pend_frame <= y_in;
                                pend_mode  <= mode;
                                pend_full  <= 1'b1;
                            end else begin
                                load_drop <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign raw_re = act_frame[(int'(idx) * 2) * DW +: DW];
    assign raw_im = act_frame[(int'(idx) * 2 + 1) * DW +: DW];

`ifdef IFFT_SCALE_EN
    // (v + 4) >>> 3 at DW+1 bits so the rounding add cannot wrap.
    function automatic logic [DW-1:0] scale(input logic [DW-1:0] v);
        logic signed [DW:0] t;
        t = {v[DW-1], v};
        t = t + {{(DW-2){1'b0}}, 3'd4};
        t = t >>> 3;
        return t[DW-1:0];
    endfunction
`else
    logic unused_mode;
    assign unused_mode = act_mode;
`endif

    always_comb begin
        out_re = '0;
        out_im = '0;
        if (state == STREAM) begin
`ifdef IFFT_SCALE_EN
            out_re = act_mode ? scale(raw_re) : raw_re;
            out_im = act_mode ? scale(raw_im) : raw_im;
`else
            out_re = raw_re;
            out_im = raw_im;
`endif
        end
    end

    assign out_valid = (state == STREAM);
    assign out_idx   = idx;
    assign out_last  = out_valid && (idx == 3'd7);
    assign busy      = out_valid || pend_full;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Randomized bench for fft_out_serializer against a frame-queue reference model.
module tb_fft_out_serializer;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             reset, mode, load, out_ready;
    logic [16*DW-1:0] y_in;
    logic             out_valid, out_last, busy, load_drop;
    logic [DW-1:0]    out_re, out_im;
    logic [2:0]       out_idx;

    fft_out_serializer #(.DW(DW)) dut (
        .clk(clk), .reset(reset), .mode(mode), .load(load), .y_in(y_in),
        .out_ready(out_ready), .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .load_drop(load_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of accepted frames (head = streaming frame), at most two held.
    logic [16*DW-1:0] fq[$];
    logic             mq[$];
    int               hidx;
    logic             exp_drop;
    int               nxfer, ndrop;

    function automatic logic [DW-1:0] elem(input logic [16*DW-1:0] f, input logic m, input int k, input bit im);
        logic [DW-1:0] raw;
        int v;
        raw = f[(2 * k + (im ? 1 : 0)) * DW +: DW];
        v = int'($signed(raw));
`ifdef IFFT_SCALE_EN
        if (m) v = (v + 4) >>> 3;
`else
        if (m) v = v;
`endif
        return v[DW-1:0];
    endfunction

    // {valid, idx, last, busy, drop, re, im}; data zeroed when not valid
    function automatic logic [2*DW+6:0] exp_vec();
        logic v;
        logic [DW-1:0] re, im;
        v = fq.size() > 0;
        re = '0; im = '0;
        if (v) begin
            re = elem(fq[0], mq[0], hidx, 1'b0);
            im = elem(fq[0], mq[0], hidx, 1'b1);
        end
        return {v, 3'(hidx), v && hidx == 7, v, exp_drop, re, im};
    endfunction

    function automatic logic [2*DW+6:0] obs_vec();
        return {out_valid, out_idx, out_last, busy, load_drop,
                out_valid ? out_re : '0, out_valid ? out_im : '0};
    endfunction

    task automatic cyc(input bit rst, input bit ld, input logic [16*DW-1:0] y, input bit md, input bit rdy);
        int cnt;
        bit xf, lst;
        reset = rst; load = ld; y_in = y; mode = md; out_ready = rdy;
        @(posedge clk);
        if (rst) begin
            fq.delete(); mq.delete(); hidx = 0; exp_drop = 0;
        end else begin
            cnt = fq.size();
            xf = cnt > 0 && rdy;
            lst = xf && hidx == 7;
            exp_drop = ld && !(cnt < 2 || lst);
            if (xf) nxfer++;
            if (exp_drop) ndrop++;
            if (lst) begin void'(fq.pop_front()); void'(mq.pop_front()); hidx = 0; end
            else if (xf) hidx++;
            if (ld && !exp_drop) begin fq.push_back(y); mq.push_back(md); end
        end
        #1;
    endtask

    function automatic logic [16*DW-1:0] rand_frame();
        logic [16*DW-1:0] f;
        for (int i = 0; i < 16; i++) f[i*DW +: DW] = DW'($urandom);
        return f;
    endfunction

    task automatic test_reset();
        cyc(1, 1, rand_frame(), 1, 1);
        cyc(1, 0, '0, 0, 1);
        checks++;
        if ({out_valid, out_last, busy, load_drop, out_re, out_im, out_idx} !== '0) begin
            errors++;
            $display("FAIL reset: got v=%b l=%b b=%b d=%b re=%h im=%h idx=%0d want all zero",
                     out_valid, out_last, busy, load_drop, out_re, out_im, out_idx);
        end
    endtask

    task automatic test_basic();
        logic [16*DW-1:0] f;
        int lastcnt = 0;
        for (int k = 0; k < 8; k++) begin
            f[2*k*DW +: DW] = DW'(k * 32'h1000);
            f[(2*k+1)*DW +: DW] = DW'(-k * 32'h1000);
        end
        nxfer = 0;
        cyc(0, 1, f, 0, 1);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL basic c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (out_last) lastcnt++;
            cyc(0, 0, '0, 0, 1);
        end
        checks++;
        if (nxfer != 8 || lastcnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: got xfers=%0d lasts=%0d busy=%b want 8 1 0", nxfer, lastcnt, busy);
        end
    endtask

    task automatic test_backpressure();
        nxfer = 0;
        cyc(0, 1, rand_frame(), 0, 1);
        for (int c = 0; c < 26; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL backpressure c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            cyc(0, 0, '0, 0, (c % 3) == 0);
        end
        checks++;
        if (nxfer != 8 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_count: got xfers=%0d valid=%b want 8 0", nxfer, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [16*DW-1:0] b;
        bit gap = 0;
        b = rand_frame();
        nxfer = 0; ndrop = 0;
        cyc(0, 1, rand_frame(), 0, 1);
        for (int c = 0; c < 18; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL back_to_back c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c < 16 && !out_valid) gap = 1;
            cyc(0, hidx == 3 && fq.size() == 1 && nxfer < 8, b, 0, 1);
        end
        checks++;
        if (gap || nxfer != 16 || ndrop != 0) begin
            errors++;
            $display("FAIL back_to_back_flow: got gap=%0b xfers=%0d drops=%0d want 0 16 0", gap, nxfer, ndrop);
        end
    endtask

    task automatic test_overflow();
        int dropcyc = 0;
        nxfer = 0; ndrop = 0;
        cyc(0, 1, rand_frame(), 0, 1);
        cyc(0, 1, rand_frame(), 0, 1);
        cyc(0, 1, rand_frame(), 0, 0);
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (load_drop) dropcyc++;
            cyc(0, 0, '0, 0, 1);
        end
        checks++;
        if (dropcyc != 1 || ndrop != 1 || nxfer != 16 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overflow_sum: got dropcyc=%0d drops=%0d xfers=%0d busy=%b want 1 1 16 0",
                     dropcyc, ndrop, nxfer, busy);
        end
    endtask

    task automatic test_scale();
        logic [16*DW-1:0] f;
        logic [DW-1:0] want_re, want_im;
        f = rand_frame();
        f[DW-1:0] = 16'h0FFC;
        f[2*DW-1:DW] = 16'h8000;
        for (int m = 1; m >= 0; m--) begin
`ifdef IFFT_SCALE_EN
            want_re = m ? 16'h0200 : 16'h0FFC;
            want_im = m ? 16'hF000 : 16'h8000;
`else
            want_re = 16'h0FFC;
            want_im = 16'h8000;
`endif
            cyc(0, 1, f, m[0], 0);
            checks++;
            if (out_valid !== 1'b1 || out_re !== want_re || out_im !== want_im) begin
                errors++;
                $display("FAIL scale_m%0d: got v=%b %h/%h want 1 %h/%h", m, out_valid, out_re, out_im, want_re, want_im);
            end
            for (int c = 0; c < 9; c++) begin
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL scale_stream c%0d: got %h want %h", c, obs_vec(), exp_vec());
                end
                cyc(0, 0, '0, 0, 1);
            end
        end
    endtask

    task automatic test_reset_midframe();
        cyc(0, 1, rand_frame(), 0, 1);
        for (int c = 0; c < 20 && hidx != 4; c++) cyc(0, 0, '0, 0, 1);
        cyc(1, 1, rand_frame(), 1, 1);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got valid=%b busy=%b want 0 0", out_valid, busy);
        end
        cyc(0, 0, '0, 0, 1);
        cyc(0, 1, rand_frame(), 0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid_reload: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            cyc(0, ($urandom % 4) == 0, rand_frame(), 1'($urandom), ($urandom % 3) != 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                if (bad++ < 10) $display("FAIL random c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        reset = 1; load = 0; mode = 0; out_ready = 0; y_in = '0;
        hidx = 0; exp_drop = 0; nxfer = 0; ndrop = 0;
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_scale();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_out_serializer.md
FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 The block SHALL provide parameter DW, default 16, as the width of each real/imag sample in Q4.12 two's complement.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mode  input  1  0 = FFT frame, 1 = IFFT frame; sampled together with y_in when load is high.
REQ-005 load  input  1  one-cycle strobe: y_in holds a complete 8-point result frame.
REQ-006 y_in  input  16*DW  element k real at [2k*DW +: DW], imag at [(2k+1)*DW +: DW], k = 0..7.
REQ-007 out_ready  input  1  downstream accepts the current element.
REQ-008 out_valid  output  1  out_re/out_im/out_idx/out_last are valid.
REQ-009 out_re, out_im  output  DW each  current element, signed.
REQ-010 out_idx  output  3  index k of the current element.
REQ-011 out_last  output  1  high when out_idx == 7 and out_valid is high.
REQ-012 busy  output  1  high while the active or pending frame buffer is occupied.
REQ-013 load_drop  output  1  one-cycle pulse when a load is discarded.

Function
REQ-014 The block SHALL hold two frame buffers, ACTIVE and PENDING, each storing 8 complex samples plus that frame's mode bit.
REQ-015 FSM SHALL have states IDLE (ACTIVE empty) and STREAM (ACTIVE holds a frame); out_valid SHALL equal (state == STREAM).
REQ-016 In IDLE, load SHALL capture y_in/mode into ACTIVE, go to STREAM, and set idx=0; out_valid SHALL rise on the cycle after load (latency 1).
REQ-017 A transfer SHALL occur on each edge where out_valid && out_ready; idx SHALL then increment. Outputs SHALL hold stable while out_valid && !out_ready.
REQ-018 On the transfer of idx 7: if PENDING is full, PENDING SHALL move to ACTIVE with idx=0, with no bubble cycle; otherwise the FSM SHALL return to IDLE.
REQ-019 A load in STREAM with PENDING empty SHALL be captured into PENDING.
REQ-020 A load coinciding with the idx-7 transfer and PENDING empty SHALL be captured directly into ACTIVE; streaming SHALL continue at idx 0 the next cycle.
REQ-021 A load coinciding with the idx-7 transfer and PENDING full SHALL be captured into PENDING while the old PENDING moves to ACTIVE.
REQ-022 A load in STREAM with PENDING full and no idx-7 transfer SHALL be discarded; load_drop SHALL pulse high for exactly the following cycle, and buffer contents SHALL be unchanged.
REQ-023 busy SHALL be high whenever state == STREAM or PENDING is full.

Reset
REQ-024 While reset is high at a rising edge, the block SHALL set state=IDLE, PENDING empty, idx=0, out_valid=0, out_last=0, busy=0, load_drop=0, out_re=0, out_im=0.
REQ-025 Reset SHALL take priority over load and out_ready; an in-flight frame SHALL be abandoned without any further transfers.

Configuration
REQ-026 With macro IFFT_SCALE_EN defined, elements of frames captured with mode=1 SHALL be output as (v + 4) >>> 3, computed at DW+1 bits and truncated to DW (1/N scaling with round-half-up). FFT frames SHALL pass unchanged.
REQ-027 Without IFFT_SCALE_EN, all elements SHALL pass through unmodified regardless of mode; mode SHALL still be stored but SHALL have no effect on the data.

Verification
REQ-028 Reset, then load a frame with elements k = k*0x1000 (re) and -k*0x1000 (im), out_ready=1 -> out_valid rises 1 cycle later; 8 consecutive transfers idx 0..7 match; out_last is high only on idx 7; then IDLE and busy=0.
REQ-029 Backpressure: out_ready toggles 1,0,0,1... -> each element is held stable while stalled; no element is skipped or duplicated; 8 transfers total.
REQ-030 Back-to-back: frame A loaded, frame B loaded at A's idx 3 -> A idx 0..7 then B idx 0..7 with no bubble; load_drop stays 0.
REQ-031 Overflow: A streaming, B pending, C loaded with out_ready=0 -> load_drop pulses one cycle; output shows A then B; C never appears.
REQ-032 IFFT_SCALE_EN defined, mode=1, element 0x0FFC / 0x8000 -> out 0x0200 / 0xF000; with mode=0 -> out 0x0FFC / 0x8000 unchanged.
REQ-033 Reset asserted at A's idx 4 -> out_valid=0 the next cycle, busy=0; a fresh load afterwards streams from idx 0.
